sr_latch_sequencer: RTL and testbench
=====================================

// Module: sr_latch_sequencer
// PURPOSE
//   Shares a bank of NUM_LATCH cross-coupled NOR SR latches between N_REQ requesters.
//   Round-robin arbitrates set/clear requests and drives one latch at a time with a timed S or R pulse.
//   Holds both inputs low for a settle gap after every pulse. Never drives S and R together on any latch.
//   Sits between control logic and the latch bank; S/R outputs connect directly to the latch inputs.
// PARAMETERS
//   N_REQ      4  number of requesters (>=2)
//   NUM_LATCH  8  latches in the bank (>=2); IW = $clog2(NUM_LATCH)
//   PULSE_W    2  cycles S or R is held high (>=1)
//   GAP_W      1  settle cycles with S=R=0 after a pulse (>=1)
// PORTS
//   clk        in   1              rising-edge clock
//   rst_n      in   1              asynchronous, active-low reset
//   req_valid  in   N_REQ          request pending, per requester
//   req_op     in   N_REQ          1=set, 0=clear, per requester
//   req_idx    in   N_REQ*IW       target latch index, packed per requester
//   req_ready  out  N_REQ          one-hot, 1-cycle grant; the request is consumed on that cycle
//   s_out      out  NUM_LATCH      S drive to latch bank
//   r_out      out  NUM_LATCH      R drive to latch bank
//   q_in       in   NUM_LATCH      latch Q readback, same clock domain
//   busy       out  1              high in every state except IDLE
//   done       out  1              1-cycle pulse when an operation completes
//   err        out  1              sticky readback mismatch flag (feature-dependent)
// BEHAVIOUR
//   Reset (async): s_out=r_out=0, req_ready=0, busy=0, done=0, err=0, RR pointer=0, FSM=IDLE.
//   - Latch contents are retained through reset because both inputs go low.
//   - Reset during PULSE truncates the pulse; the latch state is then undefined to software.
//   FSM states: IDLE -> PULSE -> SETTLE -> [CHECK] -> IDLE.
//   IDLE:
//   - If any req_valid is high, grant the first valid requester at or after the RR pointer, mod N_REQ.
//   - Assert req_ready[g] combinationally in that cycle.
//   - Register op and idx; set the RR pointer to g+1 mod N_REQ.
//   - If no req_valid is high, do nothing.
//   PULSE:
//   - Drive exactly PULSE_W cycles; s_out[idx]=op and r_out[idx]=~op; all other bits are 0.
//   SETTLE:
//   - Hold GAP_W cycles with all outputs 0.
//   CHECK:
//   - Hold 1 cycle. If q_in[idx] != op, set err; err stays set until reset.
//   Completion and next grant:
//   - done pulses in the final cycle before IDLE: CHECK, or the last SETTLE cycle when the feature is off.
//   - The earliest next grant is in the IDLE cycle after done.
//   - Latency grant->done = PULSE_W+GAP_W+1 cycles with the feature on; PULSE_W+GAP_W without it.
//   req_ready is only ever high in IDLE; requests that arrive while busy wait with valid held.
//   A request to a latch already in the target state is still pulsed; behaviour stays deterministic.
//   req_idx >= NUM_LATCH: the request is granted and consumed, no pulse is issued, err is set, and done pulses.
//   The S and R bit vectors are driven from registers, so they are glitch-free.
//   Invariant: (s_out & r_out) == 0 and popcount(s_out|r_out) <= 1 in every cycle.
//   Counters are $clog2(max(PULSE_W,GAP_W)+1) bits wide and load on state entry.
// CONFIGURATION
//   SR_SEQ_READBACK_EN defined:
//   - CHECK state exists; err behaves as described above.
//   SR_SEQ_READBACK_EN undefined:
//   - There is no CHECK state; q_in is unused.
//   - err is 0 except for an out-of-range idx, which still sets it.
// STRUCTURE
//   Package sr_seq_pkg: state enum {IDLE,PULSE,SETTLE,CHECK}, OP_SET=1'b1, OP_CLR=1'b0.
//   Sub-module rr_arbiter:
//   - Parameter N.
//   - Inputs: req[N], ptr, en. Outputs: one-hot gnt[N], gnt_idx.
//   - Purely combinational; the pointer register lives in the parent.
// TESTING
//   1. Single set, PULSE_W=2, GAP_W=1: req0 op=1 idx=3 -> s_out=8'h08 for 2 cycles, then 0; done 4 cycles after grant; err=0.
//   2. Contention: req0..3 all valid from reset -> grants in order 0,1,2,3, then 0 again; each grant one cycle, spaced by full op length.
//   3. Mutual exclusion: random ops to random idx for 10k cycles -> assertion (s_out&r_out)==0 and onehot0(s_out|r_out) never fires.
//   4. Readback (feature on): model latch stuck at 0, set idx 5 -> err rises in CHECK and stays high through later good ops.
//   5. Reset mid-PULSE: drop rst_n in PULSE cycle 1 -> s_out/r_out/busy go 0 with no clock edge; after release FSM=IDLE and ptr=0.
//   6. Out-of-range: NUM_LATCH=6, idx=7 -> no S/R activity, err=1, done pulses, requester released.

Source files
------------

// File: rtl/sr_seq_pkg.sv
// Shared types and constants for the SR latch sequencer.
package sr_seq_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    PULSE  = 2'd1,
    SETTLE = 2'd2,
    CHECK  = 2'd3
  } state_t;

  localparam logic OP_SET = 1'b1;
  localparam logic OP_CLR = 1'b0;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: grants the first request at or after ptr.
// The pointer register is owned by the instantiating module.
module rr_arbiter #(
  parameter int N = 4,
  localparam int W = $clog2(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  input  logic         en,
  output logic [N-1:0] gnt,
  output logic [W-1:0] gnt_idx
);

  logic [W-1:0] j;

  // Scan offsets from farthest to nearest so the nearest valid request wins.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    j       = '0;
    if (en) begin
      for (int i = N - 1; i >= 0; i--) begin
        j = W'((int'(ptr) + i) % N);
        if (req[j]) begin
          gnt     = '0;
          gnt[j]  = 1'b1;
          gnt_idx = j;
        end
      end
    end
  end

endmodule

// File: rtl/sr_latch_sequencer.sv
// Round-robin sequencer driving timed S/R pulses into a bank of NOR SR latches.
// Define SR_SEQ_READBACK_EN to add the CHECK state that compares q_in after each pulse.
//
// state  | meaning
// IDLE   | arbitrate requests, grant and launch a pulse
// PULSE  | drive S or R of the selected latch for PULSE_W cycles
// SETTLE | all drives low for GAP_W cycles
// CHECK  | one cycle readback compare of q_in (readback build only)
module sr_latch_sequencer
  import sr_seq_pkg::*;
#(
  parameter int N_REQ     = 4,
  parameter int NUM_LATCH = 8,
  parameter int PULSE_W   = 2,
  parameter int GAP_W     = 1,
  localparam int IW = $clog2(NUM_LATCH),
  localparam int PW = $clog2(N_REQ)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [N_REQ-1:0]      req_valid,
  input  logic [N_REQ-1:0]      req_op,
  input  logic [N_REQ*IW-1:0]   req_idx,
  output logic [N_REQ-1:0]      req_ready,
  output logic [NUM_LATCH-1:0]  s_out,
  output logic [NUM_LATCH-1:0]  r_out,
  input  logic [NUM_LATCH-1:0]  q_in,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  localparam int CW = $clog2(max_int(PULSE_W, GAP_W) + 1);

  state_t               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [PW-1:0]        ptr_q, ptr_d;
  logic                 op_q, op_d;
  logic [IW-1:0]        idx_q, idx_d;
  logic                 oor_q, oor_d;
  logic                 err_q, err_d;
  logic [NUM_LATCH-1:0] s_q, s_d, r_q, r_d;

  logic [N_REQ-1:0]     gnt;
  logic [PW-1:0]        gnt_idx;
  logic                 op_new;
  logic [IW-1:0]        idx_new;
  logic                 oor_new;
  logic [NUM_LATCH-1:0] sel_new, sel_q;

  rr_arbiter #(.N(N_REQ)) u_arb (
    .req     (req_valid),
    .ptr     (ptr_q),
    .en      (state_q == IDLE),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  assign op_new  = req_op[gnt_idx];
  assign idx_new = req_idx[int'(gnt_idx)*IW +: IW];
  assign oor_new = (int'(idx_new) >= NUM_LATCH);
  // Out-of-range targets select no latch, so no drive can ever reach the bank.
  assign sel_new = oor_new ? '0 : (NUM_LATCH'(1) << idx_new);
  assign sel_q   = oor_q   ? '0 : (NUM_LATCH'(1) << idx_q);

`ifndef SR_SEQ_READBACK_EN
  logic unused_q;
  assign unused_q = ^q_in;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ptr_q   <= '0;
      op_q    <= OP_CLR;
      idx_q   <= '0;
      oor_q   <= 1'b0;
      err_q   <= 1'b0;
      s_q     <= '0;
      r_q     <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
      op_q    <= op_d;
      idx_q   <= idx_d;
      oor_q   <= oor_d;
      err_q   <= err_d;
      s_q     <= s_d;
      r_q     <= r_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    op_d    = op_q;
    idx_d   = idx_q;
    oor_d   = oor_q;
    err_d   = err_q;
    s_d     = '0;
    r_d     = '0;
    done    = 1'b0;
    case (state_q)
      IDLE: begin
        if (|gnt) begin
          ptr_d   = (gnt_idx == PW'(N_REQ - 1)) ? '0 : gnt_idx + PW'(1);
          op_d    = op_new;
          idx_d   = idx_new;
          oor_d   = oor_new;
          err_d   = err_q | oor_new;
          s_d     = (op_new == OP_SET) ? sel_new : '0;
          r_d     = (op_new == OP_CLR) ? sel_new : '0;
          cnt_d   = CW'(PULSE_W);
          state_d = PULSE;
        end
      end
      PULSE: begin
        if (cnt_q == CW'(1)) begin
          cnt_d   = CW'(GAP_W);
          state_d = SETTLE;
        end else begin
          cnt_d = cnt_q - CW'(1);
          s_d   = (op_q == OP_SET) ? sel_q : '0;
          r_d   = (op_q == OP_CLR) ? sel_q : '0;
        end
      end
      SETTLE: begin
        if (cnt_q == CW'(1)) begin
`ifdef SR_SEQ_READBACK_EN
          state_d = CHECK;
`else
          done    = 1'b1;
          state_d = IDLE;
`endif
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
`ifdef SR_SEQ_READBACK_EN
      CHECK: begin
        done    = 1'b1;
        state_d = IDLE;
        if (!oor_q && ((|(q_in & sel_q)) != op_q)) err_d = 1'b1;
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  assign req_ready = gnt;
  assign s_out     = s_q;
  assign r_out     = r_q;
  assign busy      = (state_q != IDLE);
  assign err       = err_q;

endmodule

// File: tb/tb_sr_latch_sequencer.sv
// Directed self-checking bench for sr_latch_sequencer (8-latch and 6-latch instances).
module tb_sr_latch_sequencer;

  localparam int PW = 2;
  localparam int GW = 1;
`ifdef SR_SEQ_READBACK_EN
  localparam int LAT = PW + GW + 1;
  localparam logic EXP_RB = 1'b1;
`else
  localparam int LAT = PW + GW;
  localparam logic EXP_RB = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [3:0]  req_valid = '0, req_op = '0, req_ready;
  logic [11:0] req_idx = '0;
  logic [7:0]  s_out, r_out, q_in, q_lat = '0, stuck0 = '0;
  logic        busy, done, err;

  logic [3:0]  req_valid6 = '0, req_op6 = '0, req_ready6;
  logic [11:0] req_idx6 = '0;
  logic [5:0]  s_out6, r_out6, q_in6, q_lat6 = '0;
  logic        busy6, done6, err6;

  int n_checks = 0;
  int n_pass = 0;

  sr_latch_sequencer #(.N_REQ(4), .NUM_LATCH(8), .PULSE_W(PW), .GAP_W(GW)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_op(req_op), .req_idx(req_idx),
    .req_ready(req_ready), .s_out(s_out), .r_out(r_out), .q_in(q_in),
    .busy(busy), .done(done), .err(err)
  );

  sr_latch_sequencer #(.N_REQ(4), .NUM_LATCH(6), .PULSE_W(PW), .GAP_W(GW)) dut6 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid6), .req_op(req_op6), .req_idx(req_idx6),
    .req_ready(req_ready6), .s_out(s_out6), .r_out(r_out6), .q_in(q_in6),
    .busy(busy6), .done(done6), .err(err6)
  );

  // Behavioural NOR latch bank; stuck0 forces selected readback bits low.
  always @(posedge clk) begin
    q_lat  <= (q_lat | s_out) & ~r_out;
    q_lat6 <= (q_lat6 | s_out6) & ~r_out6;
  end
  assign q_in  = q_lat & ~stuck0;
  assign q_in6 = q_lat6;

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    req_valid = '0;
    req_valid6 = '0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b0;
    req_valid = '0;
    #1;
    n_checks++; if ({s_out, r_out} !== 16'h0) $display("FAIL reset_sr: got %h want 0000", {s_out, r_out}); else n_pass++;
    n_checks++; if ({busy, done, err} !== 3'b000) $display("FAIL reset_flags: got %b want 000", {busy, done, err}); else n_pass++;
    n_checks++; if (req_ready !== 4'b0) $display("FAIL reset_ready: got %b want 0000", req_ready); else n_pass++;
    n_checks++; if ({busy6, done6, err6, s_out6, r_out6} !== 15'h0) $display("FAIL reset_dut6: got %h want 0", {busy6, done6, err6, s_out6, r_out6}); else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_single_set();
    @(negedge clk);
    req_valid = 4'b0001; req_op = 4'b0001; req_idx = '0; req_idx[2:0] = 3'd3;
    #1;
    n_checks++; if (req_ready !== 4'b0001) $display("FAIL single_grant: got %b want 0001", req_ready); else n_pass++;
    for (int k = 1; k <= LAT + 1; k++) begin
      @(negedge clk);
      req_valid = '0;
      #1;
      if (k <= LAT) begin
        n_checks++; if (s_out !== ((k <= PW) ? 8'h08 : 8'h00)) $display("FAIL single_s k=%0d: got %h want %h", k, s_out, (k <= PW) ? 8'h08 : 8'h00); else n_pass++;
        n_checks++; if (r_out !== 8'h00) $display("FAIL single_r k=%0d: got %h want 00", k, r_out); else n_pass++;
        n_checks++; if (done !== (k == LAT)) $display("FAIL single_done k=%0d: got %b want %b", k, done, (k == LAT)); else n_pass++;
        n_checks++; if (busy !== 1'b1) $display("FAIL single_busy k=%0d: got %b want 1", k, busy); else n_pass++;
      end else begin
        n_checks++; if ({busy, done} !== 2'b00) $display("FAIL single_idle: got %b want 00", {busy, done}); else n_pass++;
      end
    end
    n_checks++; if (err !== 1'b0) $display("FAIL single_err: got %b want 0", err); else n_pass++;
  endtask

  task automatic test_contention();
    int ngr = 0;
    int last_c = 0;
    logic [3:0] exp_g;
    apply_reset();
    @(negedge clk);
    req_valid = 4'hF; req_op = 4'b1101;
    req_idx = {3'd3, 3'd2, 3'd1, 3'd0};
    #1;
    for (int c = 0; c < 5 * (LAT + 1) + 5 && ngr < 5; c++) begin
      if (c > 0) begin
        @(negedge clk);
        #1;
      end
      if (req_ready !== 4'b0) begin
        exp_g = 4'b0001 << (ngr % 4);
        n_checks++; if (req_ready !== exp_g) $display("FAIL rr_order #%0d: got %b want %b", ngr, req_ready, exp_g); else n_pass++;
        if (ngr > 0) begin
          n_checks++; if (c - last_c != LAT + 1) $display("FAIL rr_spacing #%0d: got %0d want %0d", ngr, c - last_c, LAT + 1); else n_pass++;
        end
        last_c = c;
        ngr++;
      end
    end
    n_checks++; if (ngr != 5) $display("FAIL rr_count: got %0d want 5", ngr); else n_pass++;
    @(negedge clk);
    req_valid = '0;
    repeat (LAT + 1) @(negedge clk);
  endtask

  task automatic test_mutex();
    for (int c = 0; c < 10000; c++) begin
      @(negedge clk);
      req_valid = 4'($urandom);
      req_op    = 4'($urandom);
      req_idx   = 12'($urandom);
      #1;
      n_checks++; if ((s_out & r_out) !== 8'h00) $display("FAIL mutex_sr c=%0d: got s=%h r=%h want disjoint", c, s_out, r_out); else n_pass++;
      n_checks++; if (!$onehot0(s_out | r_out)) $display("FAIL mutex_onehot c=%0d: got %h want onehot0", c, s_out | r_out); else n_pass++;
    end
    @(negedge clk);
    req_valid = '0;
    repeat (LAT + 2) @(negedge clk);
    n_checks++; if ({busy, err} !== 2'b00) $display("FAIL mutex_end: got busy,err=%b want 00", {busy, err}); else n_pass++;
  endtask

  task automatic test_readback();
    stuck0 = 8'h20;
    @(negedge clk);
    req_valid = 4'b0010; req_op = 4'b0010; req_idx = '0; req_idx[5:3] = 3'd5;
    #1;
    n_checks++; if (req_ready !== 4'b0010) $display("FAIL rb_grant: got %b want 0010", req_ready); else n_pass++;
    for (int k = 1; k <= LAT; k++) begin
      @(negedge clk);
      req_valid = '0;
      #1;
      if (k == 1) begin
        n_checks++; if (s_out !== 8'h20) $display("FAIL rb_s: got %h want 20", s_out); else n_pass++;
      end
    end
    n_checks++; if (done !== 1'b1) $display("FAIL rb_done: got %b want 1", done); else n_pass++;
    @(negedge clk);
    #1;
    n_checks++; if (err !== EXP_RB) $display("FAIL rb_err: got %b want %b", err, EXP_RB); else n_pass++;
    @(negedge clk);
    req_valid = 4'b0100; req_op = 4'b0100; req_idx = '0; req_idx[8:6] = 3'd2;
    #1;
    n_checks++; if (req_ready !== 4'b0100) $display("FAIL rb_grant2: got %b want 0100", req_ready); else n_pass++;
    repeat (LAT + 1) begin
      @(negedge clk);
      req_valid = '0;
    end
    #1;
    n_checks++; if (err !== EXP_RB) $display("FAIL rb_err_sticky: got %b want %b", err, EXP_RB); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL rb_idle: got %b want 0", busy); else n_pass++;
    stuck0 = '0;
  endtask

  task automatic test_reset_mid_pulse();
    @(negedge clk);
    req_valid = 4'b0100; req_op = 4'b0000; req_idx = '0; req_idx[8:6] = 3'd4;
    #1;
    n_checks++; if (req_ready !== 4'b0100) $display("FAIL rmp_grant: got %b want 0100", req_ready); else n_pass++;
    @(negedge clk);
    req_valid = '0;
    #1;
    n_checks++; if ({s_out, r_out} !== {8'h00, 8'h10}) $display("FAIL rmp_pulse: got %h want 0010", {s_out, r_out}); else n_pass++;
    rst_n = 1'b0;
    #1;
    n_checks++; if ({s_out, r_out} !== 16'h0) $display("FAIL rmp_sr: got %h want 0000", {s_out, r_out}); else n_pass++;
    n_checks++; if ({busy, done, err} !== 3'b000) $display("FAIL rmp_flags: got %b want 000", {busy, done, err}); else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    req_valid = 4'hF; req_op = 4'hF; req_idx = {3'd7, 3'd6, 3'd5, 3'd4};
    #1;
    n_checks++; if (req_ready !== 4'b0001) $display("FAIL rmp_ptr: got %b want 0001", req_ready); else n_pass++;
    @(negedge clk);
    req_valid = '0;
    repeat (LAT + 1) @(negedge clk);
  endtask

  task automatic test_out_of_range();
    @(negedge clk);
    req_valid6 = 4'b0001; req_op6 = 4'b0001; req_idx6 = '0; req_idx6[2:0] = 3'd7;
    #1;
    n_checks++; if (req_ready6 !== 4'b0001) $display("FAIL oor_grant: got %b want 0001", req_ready6); else n_pass++;
    for (int k = 1; k <= LAT; k++) begin
      @(negedge clk);
      req_valid6 = '0;
      #1;
      n_checks++; if ((s_out6 | r_out6) !== 6'h0) $display("FAIL oor_sr k=%0d: got %h want 00", k, s_out6 | r_out6); else n_pass++;
      n_checks++; if (done6 !== (k == LAT)) $display("FAIL oor_done k=%0d: got %b want %b", k, done6, (k == LAT)); else n_pass++;
      n_checks++; if (err6 !== 1'b1) $display("FAIL oor_err k=%0d: got %b want 1", k, err6); else n_pass++;
    end
    @(negedge clk);
    req_valid6 = 4'b0010; req_op6 = 4'b0010; req_idx6 = '0; req_idx6[5:3] = 3'd2;
    #1;
    n_checks++; if (req_ready6 !== 4'b0010) $display("FAIL oor_release: got %b want 0010", req_ready6); else n_pass++;
    @(negedge clk);
    req_valid6 = '0;
    #1;
    n_checks++; if (s_out6 !== 6'h04) $display("FAIL oor_next_s: got %h want 04", s_out6); else n_pass++;
    repeat (LAT + 1) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_single_set();
    test_contention();
    test_mutex();
    test_readback();
    test_reset_mid_pulse();
    test_out_of_range();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
